// File: rtl/vec_chunk_fifo_if.sv
// Chunk stream bundle between a vector producer, vec_chunk_fifo and the
// downstream vector stage. The slave modport is the FIFO side.
interface vec_chunk_fifo_if #(
  parameter int WorkingRegs = 4,
  parameter int DepthVecs   = 2
);
  localparam int VecW = $clog2(DepthVecs + 1);

  logic                               wr_valid;
  logic signed [WorkingRegs-1:0][7:0] wr_data;
  logic                               wr_ready;
  logic                               req_chunk_in;
  logic signed [WorkingRegs-1:0][7:0] in_data;
  logic                               in_data_ready;
  logic [VecW-1:0]                    vec_count;
  logic                               overflow;
  logic                               underflow;

  modport master (
    output wr_valid, wr_data, req_chunk_in,
    input  wr_ready, in_data, in_data_ready, vec_count, overflow, underflow
  );

  modport slave (
    input  wr_valid, wr_data, req_chunk_in,
    output wr_ready, in_data, in_data_ready, vec_count, overflow, underflow
  );
endinterface

// File: rtl/vec_chunk_fifo.sv
// Chunk-granular vector FIFO: stores whole vectors as WorkingRegs-wide chunks,
// shows the head chunk combinationally and advertises readiness per vector.
module vec_chunk_fifo #(
  parameter int InVecLength = 16,
  parameter int WorkingRegs = 4,
  parameter int DepthVecs   = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  vec_chunk_fifo_if.slave bus
);
  localparam int ChunksPerVec = InVecLength / WorkingRegs;
  localparam int DepthChunks  = DepthVecs * ChunksPerVec;
  localparam int PtrW = (DepthChunks > 1) ? $clog2(DepthChunks) : 1;
  localparam int CntW = $clog2(DepthChunks + 1);
  localparam int SubW = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1;
  localparam int VecW = $clog2(DepthVecs + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DepthChunks);
  localparam logic [SubW-1:0] SubLast = SubW'(ChunksPerVec - 1);

  typedef logic [WorkingRegs-1:0][7:0] chunk_t;

  chunk_t mem [DepthChunks];

  logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [SubW-1:0] wr_sub_reg, wr_sub_next;
  logic [SubW-1:0] rd_sub_reg, rd_sub_next;
  logic [CntW-1:0] chunk_count_reg, chunk_count_next;
  logic [VecW-1:0] vec_count_reg, vec_count_next;
  logic            overflow_reg, overflow_next;
  logic            underflow_reg, underflow_next;

  logic   pop_accept;
  logic   push_accept;
  logic   wr_wrap;
  logic   rd_wrap;
  chunk_t head_chunk;
  chunk_t head_lanes;

  // A pop frees the head slot in the same cycle, so a full FIFO may still
  // accept a push when it is also being popped.
  assign pop_accept  = bus.req_chunk_in && (chunk_count_reg != '0);
  assign push_accept = bus.wr_valid && ((chunk_count_reg < CntFull) || pop_accept);
  assign wr_wrap     = push_accept && (wr_sub_reg == SubLast);
  assign rd_wrap     = pop_accept  && (rd_sub_reg == SubLast);

  always_comb begin
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_sub_next      = wr_sub_reg;
    rd_sub_next      = rd_sub_reg;
    chunk_count_next = chunk_count_reg;
    vec_count_next   = vec_count_reg;
    overflow_next    = overflow_reg | (bus.wr_valid & ~push_accept);
    underflow_next   = underflow_reg | (bus.req_chunk_in & ~pop_accept);

    if (push_accept) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
      wr_sub_next = wr_wrap ? '0 : wr_sub_reg + 1'b1;
    end
    if (pop_accept) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
      rd_sub_next = rd_wrap ? '0 : rd_sub_reg + 1'b1;
    end

    unique case ({push_accept, pop_accept})
      2'b10:   chunk_count_next = chunk_count_reg + 1'b1;
      2'b01:   chunk_count_next = chunk_count_reg - 1'b1;
      default: chunk_count_next = chunk_count_reg;
    endcase

    // Completion on the write side and retirement on the read side may
    // coincide; both adjustments apply and cancel.
    unique case ({wr_wrap, rd_wrap})
      2'b10:   vec_count_next = vec_count_reg + 1'b1;
      2'b01:   vec_count_next = vec_count_reg - 1'b1;
      default: vec_count_next = vec_count_reg;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      wr_sub_reg      <= '0;
      rd_sub_reg      <= '0;
      chunk_count_reg <= '0;
      vec_count_reg   <= '0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_sub_reg      <= wr_sub_next;
      rd_sub_reg      <= rd_sub_next;
      chunk_count_reg <= chunk_count_next;
      vec_count_reg   <= vec_count_next;
      overflow_reg    <= overflow_next;
      underflow_reg   <= underflow_next;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_in) begin
    if (push_accept) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  assign head_chunk = mem[rd_ptr_reg];

  for (genvar gi = 0; gi < WorkingRegs; gi++) begin : g_lane
    assign head_lanes[gi] = head_chunk[gi];
  end

  assign bus.in_data       = head_lanes;
  assign bus.in_data_ready = (vec_count_reg != '0);
  assign bus.wr_ready      = (chunk_count_reg < CntFull);
  assign bus.vec_count     = vec_count_reg;
  assign bus.overflow      = overflow_reg;
  assign bus.underflow     = underflow_reg;
endmodule

// File: doc/vec_chunk_fifo.md
# vec_chunk_fifo

Chunk-granular vector FIFO sitting in front of a streaming vector stage (bias, matmul, activation). It accepts vectors as a sequence of `WorkingRegs`-wide chunks from an upstream producer, stores up to `DepthVecs` whole vectors, and serves them to the downstream stage. It is the source side of the `in_data_ready` / `in_data` / `req_chunk_in` handshake those stages consume:

- Head chunk is visible with no read latency.
- Readiness is reported per whole vector.

## Interface

Parameters:

- `InVecLength`, 16, elements per vector; must be a multiple of `WorkingRegs`.
- `WorkingRegs`, 4, int8 elements per chunk; `ChunksPerVec = InVecLength/WorkingRegs`.
- `DepthVecs`, 2, whole-vector capacity; `DepthChunks = DepthVecs*ChunksPerVec`, power of two.

Ports:

- `clk_in`  in  1  single clock; all state updates on the rising edge.
- `rst_in`  in  1  reset; asynchronous, active-low.
- `wr_valid`  in  1  push strobe; connects to the upstream stage's `req_chunk_out`.
- `wr_data`  in  `[WorkingRegs-1:0][7:0]` signed  chunk to push.
- `wr_ready`  out  1  a push would be accepted this cycle.
- `req_chunk_in`  in  1  pop strobe from the downstream stage.
- `in_data`  out  `[WorkingRegs-1:0][7:0]` signed  head chunk.
- `in_data_ready`  out  1  at least one complete vector is held.
- `vec_count`  out  `$clog2(DepthVecs+1)`  number of complete vectors held.
- `overflow`  out  1  sticky; a push was dropped.
- `underflow`  out  1  sticky; a pop on empty was ignored.

## Operation

- **Storage:** `DepthChunks` entries × `WorkingRegs*8` bits.
- **Counters:**
  - `wr_ptr`, `rd_ptr` are `$clog2(DepthChunks)` bits and wrap naturally.
  - `chunk_count` runs 0..`DepthChunks`.
  - `wr_sub`, `rd_sub` run 0..`ChunksPerVec-1` and track the position within the current vector on each side.
- **Push:** accepted when `wr_valid && (chunk_count < DepthChunks || pop_accepted)`.
  - Writes `mem[wr_ptr]` and increments `wr_ptr`.
  - `wr_sub` wraps to 0 after `ChunksPerVec-1`. That wrap increments `vec_count` (a vector is complete).
  - `wr_valid` with no accept sets `overflow`; storage and pointers are unchanged.
- **Pop:** accepted when `req_chunk_in && chunk_count > 0`.
  - Increments `rd_ptr`.
  - `rd_sub` wraps to 0 after `ChunksPerVec-1`. That wrap decrements `vec_count`.
  - `req_chunk_in` on empty sets `underflow`; state is otherwise unchanged.
- **Simultaneous push + pop:** `chunk_count` is unchanged. Both `vec_count` adjustments apply, so the net change is the sum of both and may be 0.
- **Full + simultaneous pop:** the push is accepted (write-after-read on the same slot is legal, because the read already happened combinationally).
- **Empty + simultaneous push:** only the push is accepted. The pop sets `underflow`, and the pushed chunk appears on `in_data` next cycle.
- **Outputs:**
  - `in_data = mem[rd_ptr]`, combinational from registered `rd_ptr`; undefined (don't-care) when empty.
  - `in_data_ready = (vec_count != 0)`.
  - `wr_ready = (chunk_count < DepthChunks)`.
- **Partial vectors:** a partially written vector is never advertised. A consumer that has started a vector may pop its remaining chunks once they exist; each pop is gated only by `chunk_count > 0`.
- **Flags:** `overflow` and `underflow` clear only on reset.
- **Data path:** no arithmetic; data passes through bit-exact, with signedness preserved.

## Timing

- **Reset** (`rst_in` low, asynchronous): pointers, subs and counts are 0; `in_data_ready=0`, `wr_ready=1`, `vec_count=0`, `overflow=0`, `underflow=0`. Memory contents are not reset.
- **Reset mid-vector:** all partial progress is discarded. The first push after release starts a new vector at `wr_sub=0`.
- **Push to visibility:** the last chunk of a vector pushed at edge N gives `in_data_ready=1` after edge N.
- **Pop:** `in_data` shows chunk k before edge N. `req_chunk_in` high at edge N makes chunk k+1 visible after N. This is zero-latency, single-cycle FIFO semantics.
- **Throughput:** one push and one pop per cycle sustained, with no bubbles.
- **Vector completion:** the pop of the last chunk at edge N drops `vec_count` after N. `in_data_ready` falls after N only if no other complete vector remains.

## Test plan

Defaults throughout: `WorkingRegs=4`, `InVecLength=16`, `DepthVecs=2` (8 chunks).

- **Reset:** assert `rst_in=0` mid-cycle with 3 chunks stored → outputs go to reset values immediately, without waiting for a clock edge. After release, push 4 chunks → `vec_count=1`.
- **Single vector:** push chunks 0x01..0x04 (each byte = chunk index) on 4 consecutive cycles → `in_data_ready` rises after the 4th edge, not the 3rd. Pop 4 cycles → `in_data` reads 01,02,03,04 in order, then `in_data_ready=0`.
- **Full:** push 8 chunks → `wr_ready=0`, `vec_count=2`. A 9th push → dropped, `overflow=1`, and contents re-read identical. Push + pop in the same cycle while full → accepted, `chunk_count` stays 8.
- **Empty pop:** `req_chunk_in=1` on empty → `underflow=1`, and pointers are unchanged (a subsequent push/pop returns the pushed data).
- **Streaming wrap-around:** 10 vectors pushed and popped concurrently at full rate, with the pop starting 4 cycles after the push → every output chunk equals its input, pointers wrap cleanly, and `in_data_ready` never drops between vectors.
- **Signed pass-through:** push chunk {-128, 127, -1, 0} → popped bytes are bit-exact 0x80, 0x7F, 0xFF, 0x00.
